// File: rtl/mac_pkg.sv
// Shared definitions for the MAC TX path: FSM encoding, default IFG size,
// and the conversion from IFG bytes to beat cycles.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_DATA = 3'b010,
    ST_IFG  = 3'b100
  } tx_state_e;

  localparam int IFG_N_DEF = 12;

  // Idle cycles needed to cover ifg_n bytes at keep_w bytes per beat.
  function automatic int ifg_cyc(input int ifg_n, input int keep_w);
    return (ifg_n + keep_w - 1) / keep_w;
  endfunction

endpackage

// File: rtl/mac_rr_arb.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module mac_rr_arb #(
  parameter int REQ_N = 2,
  parameter int IDX_W = $clog2(REQ_N)
) (
  input  logic [REQ_N-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [REQ_N-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // NOTE: every output gets a default before the search so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= REQ_N) idx = idx - REQ_N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = IDX_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arb.sv
// Packet-granular round-robin arbiter feeding the single MAC TX datapath,
// with zero-latency beat forwarding and an enforced inter-frame gap.
module mac_tx_arb
  import mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8,
  parameter int REQ_N  = 2,
  parameter int IFG_N  = IFG_N_DEF
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [REQ_N-1:0]         valid_i,
  input  logic [REQ_N*DATA_W-1:0]  data_i,
  input  logic [REQ_N*KEEP_W-1:0]  keep_i,
  input  logic [REQ_N-1:0]         last_i,
  output logic [REQ_N-1:0]         ready_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [KEEP_W-1:0]        keep_o,
  output logic                     start_o,
  output logic                     last_o,
  input  logic                     ready_i,
  output logic [REQ_N-1:0]         gnt_o
);

  localparam int IFG_CYC = ifg_cyc(IFG_N, KEEP_W);
  localparam int CNT_W   = $clog2(IFG_CYC + 1);
  localparam int IDX_W   = $clog2(REQ_N);

  tx_state_e        state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] g_idx_q;
  logic [REQ_N-1:0] gnt_q;
  logic             first_q;
  logic [CNT_W-1:0] ifg_cnt_q;

  logic [REQ_N-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [IDX_W-1:0] ptr_nxt;
  logic             in_data;
  logic             xfer;

  mac_rr_arb #(.REQ_N(REQ_N), .IDX_W(IDX_W)) u_rr_arb (
    .req     (valid_i),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign ptr_nxt = (arb_idx == IDX_W'(REQ_N - 1)) ? '0 : arb_idx + IDX_W'(1);

  // Beats pass straight through from the granted requester; the grant index
  // is the only registered part of the datapath.
  assign in_data = (state_q == ST_DATA);
  assign valid_o = in_data & valid_i[g_idx_q];
  assign data_o  = in_data ? data_i[int'(g_idx_q)*DATA_W +: DATA_W] : '0;
  assign keep_o  = in_data ? keep_i[int'(g_idx_q)*KEEP_W +: KEEP_W] : '0;
  assign last_o  = in_data & last_i[g_idx_q];
  assign start_o = valid_o & first_q;
  assign gnt_o   = gnt_q;
  assign xfer    = valid_o & ready_i;

  always_comb begin
    ready_o = '0;
    if (in_data) ready_o[g_idx_q] = ready_i;
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      g_idx_q   <= '0;
      gnt_q     <= '0;
      first_q   <= 1'b0;
      ifg_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q <= ST_DATA;
            gnt_q   <= arb_gnt;
            g_idx_q <= arb_idx;
            ptr_q   <= ptr_nxt;
            first_q <= 1'b1;
          end
        end
        ST_DATA: begin
          // No timeout: a stalled requester keeps the grant until its last beat.
          if (xfer) begin
            first_q <= 1'b0;
            if (last_o) begin
              state_q   <= ST_IFG;
              ifg_cnt_q <= CNT_W'(IFG_CYC);
              gnt_q     <= '0;
            end
          end
        end
        ST_IFG: begin
          ifg_cnt_q <= ifg_cnt_q - CNT_W'(1);
          if (ifg_cnt_q == CNT_W'(1)) begin
            if (arb_any) begin
              state_q <= ST_DATA;
              gnt_q   <= arb_gnt;
              g_idx_q <= arb_idx;
              ptr_q   <= ptr_nxt;
              first_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Directed bench for mac_tx_arb at defaults (DATA_W 16, REQ_N 2, 6 IFG cycles).
module tb_mac_tx_arb;

  logic        clk = 1'b0;
  logic        nreset;
  logic [1:0]  valid_i, last_i, ready_o, gnt_o;
  logic [31:0] data_i;
  logic [3:0]  keep_i;
  logic        valid_o, start_o, last_o, ready_i;
  logic [15:0] data_o;
  logic [1:0]  keep_o;

  int passed = 0;
  int total  = 0;

  // Source model configuration and per-cycle output traces.
  int          flen[2], nfr[2], bcnt[2];
  int          gap_at, gap_len;
  logic [63:0] rdy_pat;
  logic [63:0] tv, ts, tl;
  logic [1:0]  tg[64], tr[64], tk[64];
  logic [15:0] td[64];

  mac_tx_arb dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .data_i(data_i),
    .keep_i(keep_i), .last_i(last_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .keep_o(keep_o), .start_o(start_o), .last_o(last_o),
    .ready_i(ready_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset  = 1'b0;
    valid_i = '0;
    last_i  = '0;
    ready_i = 1'b1;
    repeat (2) tick();
    nreset = 1'b1;
  endtask

  task automatic cfg(input int f0, input int n0, input int f1, input int n1);
    flen[0] = f0; nfr[0] = n0; flen[1] = f1; nfr[1] = n1;
    bcnt[0] = 0;  bcnt[1] = 0;
    gap_at  = -1; gap_len = 0;
    rdy_pat = '1;
    tv = '0; ts = '0; tl = '0;
  endtask

  // Drives both sources for n cycles starting in the current cycle; a source
  // advances only when its beat is accepted via ready_o.
  task automatic run(input int n);
    int gap_done;
    gap_done = 0;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 2; k++) begin
        logic lst;
        lst = ((bcnt[k] % flen[k]) == flen[k] - 1);
        valid_i[k]            = (bcnt[k] < flen[k] * nfr[k]);
        last_i[k]             = lst;
        keep_i[k*2 +: 2]      = lst ? 2'b01 : 2'b11;
        data_i[k*16 +: 16]    = 16'hA000 + 16'(k * 4096) + 16'(bcnt[k]);
      end
      if (bcnt[0] == gap_at && gap_done < gap_len) begin
        valid_i[0] = 1'b0;
        gap_done++;
      end
      ready_i = rdy_pat[c];
      @(negedge clk);
      tv[c] = valid_o; ts[c] = start_o; tl[c] = last_o;
      tg[c] = gnt_o;   tr[c] = ready_o; td[c] = data_o; tk[c] = keep_o;
      for (int k = 0; k < 2; k++)
        if (valid_i[k] && ready_o[k]) bcnt[k]++;
      tick();
    end
  endtask

  task automatic test_reset();
    nreset  = 1'b0;
    valid_i = 2'b11;
    last_i  = 2'b00;
    keep_i  = 4'hF;
    data_i  = 32'hB000_A000;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      total++;
      if ({valid_o, start_o, last_o, ready_o, gnt_o, data_o, keep_o} !== '0)
        $display("FAIL reset_out%0d: got v%b s%b l%b r%b g%b d%h k%b want all 0",
                 i, valid_o, start_o, last_o, ready_o, gnt_o, data_o, keep_o);
      else passed++;
    end
    tick();
    nreset = 1'b1;
    @(negedge clk);
    total++;
    if ({valid_o, gnt_o, ready_o} !== '0)
      $display("FAIL reset_idle: got v%b g%b r%b want 0", valid_o, gnt_o, ready_o);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({gnt_o, valid_o, start_o, ready_o, data_o} !== {2'b01, 1'b1, 1'b1, 2'b01, 16'hA000})
      $display("FAIL reset_first_gnt: got g%b v%b s%b r%b d%h want g01 v1 s1 r01 dA000",
               gnt_o, valid_o, start_o, ready_o, data_o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg(4, 2, 1, 0);
    run(16);
    total++;
    if (ts[15:0] !== 16'h0802) $display("FAIL b2b_start: got %h want 0802", ts[15:0]);
    else passed++;
    total++;
    if (tv[15:0] !== 16'h781E) $display("FAIL b2b_valid: got %h want 781e", tv[15:0]);
    else passed++;
    total++;
    if (tl[15:0] !== 16'h4010) $display("FAIL b2b_last: got %h want 4010", tl[15:0]);
    else passed++;
    total++;
    if (td[11] !== 16'hA004) $display("FAIL b2b_data11: got %h want a004", td[11]);
    else passed++;
    total++;
    if ({tk[1], tk[4]} !== 4'b1101) $display("FAIL b2b_keep: got %b want 1101", {tk[1], tk[4]});
    else passed++;
    total++;
    if ({tg[5], tr[5], tg[10], tr[10]} !== '0)
      $display("FAIL b2b_ifg_idle: got %b want 0", {tg[5], tr[5], tg[10], tr[10]});
    else passed++;
    total++;
    if (tg[11] !== 2'b01) $display("FAIL b2b_gnt11: got %b want 01", tg[11]);
    else passed++;
  endtask

  task automatic test_fairness();
    do_reset();
    cfg(2, 2, 2, 2);
    run(28);
    total++;
    if ({tg[1], tg[9], tg[17], tg[25]} !== 8'b01_10_01_10)
      $display("FAIL fair_order: got %b want 01100110", {tg[1], tg[9], tg[17], tg[25]});
    else passed++;
    total++;
    if (tv[27:0] !== 28'h6060606) $display("FAIL fair_valid: got %h want 6060606", tv[27:0]);
    else passed++;
    total++;
    if ({td[9], td[17], td[25]} !== {16'hB000, 16'hA002, 16'hB002})
      $display("FAIL fair_data: got %h want b000a002b002", {td[9], td[17], td[25]});
    else passed++;
    total++;
    if ({tr[5], tr[9]} !== 4'b0010) $display("FAIL fair_ready: got %b want 0010", {tr[5], tr[9]});
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    cfg(3, 1, 1, 0);
    rdy_pat = ~64'h2A;   // cycles 1,3,5 stall
    run(8);
    total++;
    if (ts[7:0] !== 8'h06) $display("FAIL bp_start: got %h want 06", ts[7:0]);
    else passed++;
    total++;
    if (tv[7:0] !== 8'h7E) $display("FAIL bp_valid: got %h want 7e", tv[7:0]);
    else passed++;
    total++;
    if (tl[7:0] !== 8'h60) $display("FAIL bp_last: got %h want 60", tl[7:0]);
    else passed++;
    total++;
    if ({tr[1], tr[2], tr[3], tr[4], tr[5], tr[6]} !== 12'b00_01_00_01_00_01)
      $display("FAIL bp_ready: got %b want 000100010001",
               {tr[1], tr[2], tr[3], tr[4], tr[5], tr[6]});
    else passed++;
    total++;
    if ({td[2], td[3], td[4], td[5]} !== {16'hA000, 16'hA001, 16'hA001, 16'hA002})
      $display("FAIL bp_hold: got %h want a000a001a001a002", {td[2], td[3], td[4], td[5]});
    else passed++;
  endtask

  task automatic test_single_gap();
    do_reset();
    cfg(1, 1, 1, 0);
    run(4);
    total++;
    if ({ts[1], tl[1], tk[1]} !== 4'b1101)
      $display("FAIL single_start_last: got %b want 1101", {ts[1], tl[1], tk[1]});
    else passed++;
    total++;
    if ({tv[3:0], tg[2]} !== 6'b0010_00)
      $display("FAIL single_ifg: got %b want 001000", {tv[3:0], tg[2]});
    else passed++;

    do_reset();
    cfg(3, 1, 1, 1);
    gap_at  = 1;
    gap_len = 2;
    run(14);
    total++;
    if (tv[13:0] !== 14'h1032) $display("FAIL gap_valid: got %h want 1032", tv[13:0]);
    else passed++;
    total++;
    if ({tg[2], tg[3], tr[2]} !== 6'b01_01_01)
      $display("FAIL gap_hold: got %b want 010101", {tg[2], tg[3], tr[2]});
    else passed++;
    total++;
    if ({td[4], td[5]} !== {16'hA001, 16'hA002})
      $display("FAIL gap_data: got %h want a001a002", {td[4], td[5]});
    else passed++;
    total++;
    if (td[6] !== 16'h0000) $display("FAIL gap_ifg_data: got %h want 0000", td[6]);
    else passed++;
    total++;
    if ({tg[12], ts[12], tl[12], td[12]} !== {2'b10, 1'b1, 1'b1, 16'hB000})
      $display("FAIL gap_next_gnt: got %b %b%b %h want 10 11 b000", tg[12], ts[12], tl[12], td[12]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid_i = 2'b01;
    last_i  = 2'b00;
    keep_i  = 4'hF;
    data_i  = 32'h0000_A000;
    tick();
    @(negedge clk);
    total++;
    if ({start_o, gnt_o} !== 3'b101) $display("FAIL mid_first: got %b want 101", {start_o, gnt_o});
    else passed++;
    tick();
    data_i  = 32'h0000_A001;
    nreset  = 1'b0;
    tick();
    nreset = 1'b1;
    @(negedge clk);
    total++;
    if ({valid_o, start_o, last_o, ready_o, gnt_o, data_o, keep_o} !== '0)
      $display("FAIL mid_reset_out: got v%b s%b l%b r%b g%b d%h k%b want all 0",
               valid_o, start_o, last_o, ready_o, gnt_o, data_o, keep_o);
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({start_o, gnt_o, data_o} !== {1'b1, 2'b01, 16'hA001})
      $display("FAIL mid_regrant: got s%b g%b d%h want s1 g01 da001", start_o, gnt_o, data_o);
    else passed++;
  endtask

  initial begin
    nreset  = 1'b0;
    valid_i = '0;
    last_i  = '0;
    data_i  = '0;
    keep_i  = '0;
    ready_i = 1'b1;
    test_reset();
    test_back_to_back();
    test_fairness();
    test_backpressure();
    test_single_gap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mac_tx_arb.md
# mac_tx_arb

Packet-granular round-robin arbiter that shares the single MAC TX datapath between `REQ_N` upper-layer frame sources, such as the IPv4 and ARP engines. It sits between those sources and the MAC TX input. It grants one requester per frame and forwards that requester's beats with zero added latency. After every frame it enforces a minimum inter-frame gap before the next grant.

## Interface
- `DATA_W`, 16: beat width in bits (16, 32 or 64).
- `KEEP_W`, `DATA_W/8`: byte-enable width.
- `REQ_N`, 2: number of requesters, at least 2.
- `IFG_N`, 12: minimum idle bytes between frames, at least 1.

- `clk`  in  1: clock.
- `nreset`  in  1: reset, synchronous, active-low.
- `valid_i`  in  `REQ_N`: per-requester beat valid; also acts as that requester's request.
- `data_i`  in  `REQ_N*DATA_W`: requester k occupies `[k*DATA_W +: DATA_W]`.
- `keep_i`  in  `REQ_N*KEEP_W`: requester k occupies `[k*KEEP_W +: KEEP_W]`.
- `last_i`  in  `REQ_N`: marks the final beat of a frame.
- `ready_o`  out  `REQ_N`: per-requester beat accepted.
- `valid_o`  out  1: beat valid towards MAC TX.
- `data_o`  out  `DATA_W`: beat data towards MAC TX.
- `keep_o`  out  `KEEP_W`: byte enables towards MAC TX.
- `start_o`  out  1: first beat of a frame.
- `last_o`  out  1: last beat of a frame.
- `ready_i`  in  1: MAC TX accepts the beat.
- `gnt_o`  out  `REQ_N`: one-hot current grant; all zero when no frame is granted.

## Operation
- FSM states: IDLE, DATA, IFG. The state is one-hot.
- Round-robin pointer `ptr_q`: 0 to `REQ_N-1`.
- Arbitration pick: the first index k with `valid_i[k]`, searching from `ptr_q` upward with wrap. On a grant, `gnt_q` is set to one-hot k and `ptr_q` becomes k+1, wrapping to 0.
- IDLE transitions:
  - Any `valid_i` set: pick, go to DATA, set `first_q`.
  - Otherwise: stay in IDLE.
- DATA, for granted requester g:
  - `valid_o = valid_i[g]`.
  - `data_o`, `keep_o`, `last_o` are muxed from requester g.
  - `ready_o[g] = ready_i`; all other `ready_o` bits are 0.
  - `start_o = valid_o & first_q`.
  - `first_q` clears on an accepted beat (`valid_o & ready_i`).
- DATA exit: an accepted beat with `last_o` moves to IFG, loads `ifg_cnt_q = IFG_CYC`, and clears `gnt_q`.
- DATA hold: a grant is held while `valid_i[g]` is low mid-frame. There is no timeout and no preemption.
- IFG: `ifg_cnt_q` decrements each cycle. All outputs are idle and all `ready_o` are 0.
- IFG exit when `ifg_cnt_q == 1`:
  - Any `valid_i` set: pick and go directly to DATA.
  - Otherwise: go to IDLE.
- `IFG_CYC = ceil(IFG_N / KEEP_W)`. With the defaults this is 6 cycles.
- Outside DATA, `data_o`, `keep_o` and `last_o` are driven to 0.
- `valid_i` raised by non-granted requesters is ignored. They must hold their beat until granted; a requester that drops `valid_i` loses its turn without error.

## Timing
- Reset values:
  - State IDLE, `ptr_q = 0`, `gnt_q = 0`, `first_q = 0`, `ifg_cnt_q = 0`.
  - All outputs 0, including `valid_o`, `ready_o`, `start_o`, `last_o` and `gnt_o`.
- Grant latency: `valid_i[k]` high in IDLE at cycle N gives `gnt_o` and the first forwarded beat at N+1.
- Data path: combinational pass-through with no pipeline register. Handshake is standard valid/ready, with a transfer on `valid_o & ready_i`.
- Last beat accepted at cycle M:
  - Cycles M+1 to M+`IFG_CYC` are IFG.
  - Earliest next `start_o` is M+`IFG_CYC`+1.
- Single-beat frame: `start_o` and `last_o` are high together. `first_q` clears and the FSM enters IFG on the same edge.
- Simultaneous requests: only one winner per pick. For example, with `ptr_q = 1` and `valid_i = 2'b11`, requester 1 wins, then requester 0 after its IFG.
- Reset mid-frame or mid-IFG: next cycle is IDLE with all outputs 0. The partial frame is abandoned; requesters re-request.
- `ready_i` low: beat, `start_o` and `first_q` are all held.

## Structure
- `mac_pkg` holds:
  - the FSM state encoding;
  - the default `IFG_N` (12 bytes);
  - the `IFG_CYC` helper function.
- Sub-module `mac_rr_arb`: combinational round-robin pick.
  - Inputs: `req[REQ_N]`, `ptr`.
  - Outputs: `gnt[REQ_N]` one-hot, `gnt_idx`, `any`.
  - Reused by future TX schedulers.
- `mac_tx_arb` holds the FSM, `ptr_q`, `first_q`, `ifg_cnt_q` and the output mux.

## Test plan
- **Reset:** hold `nreset = 0` for 3 cycles with `valid_i = 2'b11` -> all outputs 0. The first grant after release goes to requester 0.
- **Single source, back-to-back:**
  - Stimulus: requester 0 sends two 4-beat frames back-to-back, with `ready_i = 1` and defaults (`DATA_W` 16).
  - Required: `start_o` on beats 1 and 11, giving exactly 6 idle cycles between frames.
- **Fairness:** both requesters continuously send 2-beat frames -> grants alternate 0,1,0,1. `ptr_q` wraps 1->0.
- **Backpressure:**
  - Stimulus: `ready_i` toggles 1,0,1,0 during a 3-beat frame.
  - Required: each beat is held while `ready_i = 0`, `ready_o[g]` mirrors `ready_i`, and `start_o` is seen only on the first beat.
- **Single-beat frames and gaps:**
  - Stimulus: a single-beat frame (`last_i` on the first beat), plus a mid-frame `valid_i` gap of 2 cycles.
  - Required: `start_o & last_o` on the same cycle, and the grant is held through the gap.
- **Reset mid-frame:** assert reset during beat 2 -> outputs 0 next cycle and the FSM is in IDLE.
